// File: rtl/uart_rx_axis.sv
// uart_rx_axis: UART receiver driven by an external baud prescaler.
// The prescaler is enabled while a frame is in progress. Its mid-bit strobe
// (pre_half) samples the synchronized line. Completed bytes go into a
// single-entry AXI-Stream output slot. Framing, parity and overrun errors
// are reported as one-cycle pulses.
module uart_rx_axis #(
    parameter int DATA_BITS = 8,   // 5..8
    parameter int PARITY    = 0    // 0 none, 1 even, 2 odd
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic       pre_en,
    input  logic       pre_stb,
    input  logic       pre_half,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state_q, state_d;
    logic                   meta_q, sync_q, prev_q;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   perr_q, perr_d;
    logic                   fe_q, fe_d;
    logic                   pe_q, pe_d;
    logic                   ovr_q, ovr_d;
    logic                   tvalid_q, tvalid_d;
    logic [7:0]             tdata_q, tdata_d;
    logic                   done;
    logic                   fall;
    logic                   par_exp;

    // The end-of-bit strobe is not needed to receive data.
    logic unused_pre_stb;
    assign unused_pre_stb = pre_stb;

    // The line idles high, so the synchronizer and edge registers reset to 1.
    // This avoids a false start edge after reset.
    assign fall   = prev_q & ~sync_q;
    assign pre_en = (state_q != IDLE);

    // Two-flop synchronizer followed by the edge-detect register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rxd;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Frame FSM: sample on pre_half and classify the frame at the stop bit.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        perr_d    = perr_q;
        fe_d      = 1'b0;
        pe_d      = 1'b0;
        done      = 1'b0;
        par_exp   = (^sh_q) ^ (PARITY == 2);
        case (state_q)
            IDLE: begin
                if (fall) state_d = START;
            end
            START: begin
                if (pre_half) begin
                    if (!sync_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                        perr_d    = 1'b0;
                    end else begin
                        state_d = IDLE;   // glitch, not a real start bit
                    end
                end
            end
            DATA: begin
                if (pre_half) begin
                    sh_d      = {sync_q, sh_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1))
                        state_d = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                if (pre_half) begin
                    if (sync_q != par_exp) perr_d = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (pre_half) begin
                    state_d = IDLE;
                    if (!sync_q)     fe_d = 1'b1;   // framing wins over parity
                    else if (perr_q) pe_d = 1'b1;
                    else             done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output slot: load on completion if empty or draining, otherwise overrun.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        ovr_d    = 1'b0;
        if (done) begin
            if (!tvalid_q || m_axis_tready) begin
                tvalid_d                = 1'b1;
                tdata_d                 = '0;
                tdata_d[DATA_BITS-1:0]  = sh_q;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            perr_q    <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            perr_q    <= perr_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            ovr_q     <= ovr_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_err     = fe_q;
    assign parity_err    = pe_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Bench for uart_rx_axis.
// dut0: 8N1 with div=16. dut1: 8E1 with div=8.
// Each DUT has its own behavioural prescaler model.
// Expected events are queued when stimulus is issued. A forked monitor
// pops and compares an event whenever a DUT shows a beat or an error pulse.
module tb_uart_rx_axis;

    localparam int K_BEAT = 0, K_FE = 1, K_PE = 2, K_OVR = 3;

    typedef struct {
        int         inst;
        int         kind;
        logic [7:0] data;
    } evt_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] rxd_v;
    logic [1:0] tready_v;
    logic       pre_en0, pre_en1, pre_half0, pre_half1, pre_stb0, pre_stb1;
    logic [4:0] cnt0 = 5'd0, cnt1 = 5'd0;
    logic [7:0] td0, td1;
    logic       tv0, tv1, fe0, fe1, pe0, pe1, ov0, ov1;

    evt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Prescaler models: counters held at 0 while disabled.
    always @(posedge clk) begin
        cnt0 <= pre_en0 ? ((cnt0 == 5'd15) ? 5'd0 : cnt0 + 5'd1) : 5'd0;
        cnt1 <= pre_en1 ? ((cnt1 == 5'd7)  ? 5'd0 : cnt1 + 5'd1) : 5'd0;
    end
    assign pre_half0 = pre_en0 && (cnt0 == 5'd7);
    assign pre_stb0  = pre_en0 && (cnt0 == 5'd15);
    assign pre_half1 = pre_en1 && (cnt1 == 5'd3);
    assign pre_stb1  = pre_en1 && (cnt1 == 5'd7);

    uart_rx_axis #(.DATA_BITS(8), .PARITY(0)) dut0 (
        .clk(clk), .rstn(rstn), .rxd(rxd_v[0]), .pre_en(pre_en0),
        .pre_stb(pre_stb0), .pre_half(pre_half0),
        .m_axis_tdata(td0), .m_axis_tvalid(tv0), .m_axis_tready(tready_v[0]),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
    );

    uart_rx_axis #(.DATA_BITS(8), .PARITY(1)) dut1 (
        .clk(clk), .rstn(rstn), .rxd(rxd_v[1]), .pre_en(pre_en1),
        .pre_stb(pre_stb1), .pre_half(pre_half1),
        .m_axis_tdata(td1), .m_axis_tvalid(tv1), .m_axis_tready(tready_v[1]),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events never seen, expected 0 left", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic push(input int inst, input int kind, input logic [7:0] data);
        evt_t e;
        e.inst = inst; e.kind = kind; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int inst, input int kind, input logic [7:0] data);
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: dut%0d kind %0d data %h, expected none", inst, kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.inst != inst || e.kind != kind || (kind == K_BEAT && e.data != data)) begin
                errors++;
                $display("FAIL event: got dut%0d kind %0d data %h, expected dut%0d kind %0d data %h",
                         inst, kind, data, e.inst, e.kind, e.data);
            end
        end
    endtask

    task automatic watch(input int inst, input logic fe, input logic pe, input logic ov,
                         input logic bt, input logic [7:0] d);
        if (fe) pop_cmp(inst, K_FE, 8'h00);
        if (pe) pop_cmp(inst, K_PE, 8'h00);
        if (ov) pop_cmp(inst, K_OVR, 8'h00);
        if (bt) pop_cmp(inst, K_BEAT, d);
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                watch(0, fe0, pe0, ov0, tv0 && tready_v[0], td0);
                watch(1, fe1, pe1, ov1, tv1 && tready_v[1], td1);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int inst, input logic b);
        rxd_v[inst] = b;
        idle(inst == 0 ? 16 : 8);
    endtask

    // par < 0: no parity bit, otherwise par[0] is sent.
    task automatic send(input int inst, input logic [7:0] d, input int par, input logic stop);
        drive_bit(inst, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(inst, d[i]);
        if (par >= 0) drive_bit(inst, par[0]);
        drive_bit(inst, stop);
        rxd_v[inst] = 1'b1;
    endtask

    initial begin
        rxd_v    = 2'b11;
        tready_v = 2'b11;
        rstn     = 1'b0;
        fork
            monitor_loop();
        join_none
        idle(3);
        chk("rst_tvalid0", {7'd0, tv0}, 8'h00);
        chk("rst_tdata0", td0, 8'h00);
        chk("rst_pre_en0", {7'd0, pre_en0}, 8'h00);
        chk("rst_errs0", {5'd0, fe0, pe0, ov0}, 8'h00);
        chk("rst_tvalid1", {7'd0, tv1}, 8'h00);
        chk("rst_pre_en1", {7'd0, pre_en1}, 8'h00);
        rstn = 1'b1;
        idle(4);

        // 8N1 clean byte.
        push(0, K_BEAT, 8'h5A);
        send(0, 8'h5A, -1, 1'b1);
        chk("5a_pre_en_low", {7'd0, pre_en0}, 8'h00);
        idle(10);
        chk("5a_tvalid_dropped", {7'd0, tv0}, 8'h00);
        chk_empty("5a_done");

        // Start-bit glitch.
        rxd_v[0] = 1'b0;
        idle(3);
        rxd_v[0] = 1'b1;
        idle(3);
        chk("glitch_pre_en_on", {7'd0, pre_en0}, 8'h01);
        idle(16);
        chk("glitch_pre_en_off", {7'd0, pre_en0}, 8'h00);
        chk_empty("glitch_done");

        // Stop bit 0.
        push(0, K_FE, 8'h00);
        send(0, 8'hC3, -1, 1'b0);
        idle(20);
        chk("fe_tvalid", {7'd0, tv0}, 8'h00);
        chk_empty("fe_done");

        // Even parity: 0x03 needs parity bit 0.
        push(1, K_PE, 8'h00);
        send(1, 8'h03, 1, 1'b1);
        idle(10);
        chk_empty("pe_bad_done");
        push(1, K_BEAT, 8'h03);
        send(1, 8'h03, 0, 1'b1);
        idle(10);
        chk_empty("pe_good_done");

        // Overrun: slot holds the first byte while tready is low.
        tready_v[0] = 1'b0;
        push(0, K_OVR, 8'h00);
        send(0, 8'h11, -1, 1'b1);
        send(0, 8'h22, -1, 1'b1);
        idle(4);
        chk("ovr_tvalid_held", {7'd0, tv0}, 8'h01);
        chk("ovr_tdata_held", td0, 8'h11);
        push(0, K_BEAT, 8'h11);
        tready_v[0] = 1'b1;
        idle(4);
        chk("ovr_tvalid_drop", {7'd0, tv0}, 8'h00);
        chk_empty("ovr_done");

        // Reset in the middle of a frame.
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_tvalid", {7'd0, tv0}, 8'h00);
        chk("mid_rst_tdata", td0, 8'h00);
        chk("mid_rst_pre_en", {7'd0, pre_en0}, 8'h00);
        chk("mid_rst_errs", {5'd0, fe0, pe0, ov0}, 8'h00);
        rxd_v[0] = 1'b1;
        idle(3);
        rstn = 1'b1;
        idle(40);
        chk("post_rst_idle", {7'd0, pre_en0}, 8'h00);
        push(0, K_BEAT, 8'h42);
        send(0, 8'h42, -1, 1'b1);
        idle(20);
        chk_empty("post_rst_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_axis.md
UART_RX_AXIS -- requirements
Module: uart_rx_axis

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port pre_en  output  1  enable to the baud prescaler; its counter is held at 0 while low.
REQ-007 SHALL have port pre_stb  input  1  prescaler end-of-bit pulse (counter == div-1); unused except for the monitor in REQ-028.
REQ-008 SHALL have port pre_half  input  1  prescaler mid-bit pulse (counter == div/2-1), one cycle per bit period.
REQ-009 SHALL have port m_axis_tdata  output  8  received byte, LSB-aligned, unused upper bits 0.
REQ-010 SHALL have port m_axis_tvalid  output  1  AXI-Stream valid.
REQ-011 SHALL have port m_axis_tready  input  1  AXI-Stream ready.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled 0.
REQ-013 SHALL have port parity_err  output  1  one-cycle pulse: parity mismatch.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped because the output slot was full.

Function
REQ-015 SHALL pass rxd through a 2-flop synchronizer followed by an edge register; all decisions use the synchronized value.
REQ-016 SHALL implement states IDLE, START, DATA, PAR, STOP.
REQ-017 IDLE: pre_en=0; a synchronized falling edge (previous 1, current 0) SHALL move to START and set pre_en=1 on the same clock edge.
REQ-018 START: on pre_half, sampled 0 SHALL go to DATA; sampled 1 (glitch) SHALL return to IDLE, pre_en=0, no output or error.
REQ-019 DATA: each pre_half SHALL shift the sample into a shift register LSB first; after DATA_BITS samples go to PAR if PARITY!=0, else STOP.
REQ-020 PAR: on pre_half, sample parity bit; mismatch against even/odd parity of data bits SHALL latch an internal error flag; go to STOP.
REQ-021 STOP: on pre_half, go to IDLE with pre_en=0 on the same edge; stop sample 0 SHALL pulse frame_err and discard the byte; stop 1 with parity flag set SHALL pulse parity_err and discard the byte; frame error takes precedence (only frame_err pulses).
REQ-022 A valid byte SHALL be presented with m_axis_tvalid=1 on the cycle after the stop-bit pre_half.
REQ-023 tvalid SHALL stay high and tdata stable until a cycle with tready=1; tvalid drops the following cycle unless a new byte loads on that cycle.
REQ-024 If a byte completes while tvalid=1 and tready=0, it SHALL be dropped, overrun pulses one cycle, and the held tdata is unchanged.
REQ-025 If a byte completes on the same cycle as a tvalid&&tready handshake, it SHALL be loaded, tvalid stays 1, no overrun.
REQ-026 Edge detection SHALL be active on the cycle IDLE is re-entered, so back-to-back frames with one stop bit are received.
REQ-027 pre_half seen in IDLE SHALL be ignored.
REQ-028 Supported div >= 4 and even; pre_stb SHALL not alter state (it is used only for bench cross-checking).

Reset
REQ-029 rstn low SHALL asynchronously force state IDLE, pre_en=0, m_axis_tvalid=0, m_axis_tdata=0, all error pulses 0, shift register 0, synchronizer and edge registers to 1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; after release, reception resumes only on a new falling edge.

Verification
REQ-031 div=16, 8N1, tready=1, send 0x5A -> one beat tdata=0x5A, tvalid 1 cycle, no error pulses, pre_en low after stop mid-bit.
REQ-032 div=16, rxd low for 3 clocks then high -> START aborts at first pre_half, no beat, no errors, pre_en returns 0.
REQ-033 div=16, send 0xC3 with stop bit 0 -> frame_err one-cycle pulse, tvalid stays 0.
REQ-034 PARITY=1, div=8, send 0x03 with parity bit 1 -> parity_err pulse, no beat; parity bit 0 -> beat 0x03.
REQ-035 tready=0, send 0x11 then 0x22 back-to-back -> tdata holds 0x11, overrun pulses at end of second frame; raise tready -> single beat 0x11.
REQ-036 rstn pulsed low during DATA of 0x77 -> all outputs 0 immediately; following frame 0x42 -> beat 0x42 only.
